ctrl_sequencer: RTL and testbench
=================================

# ctrl_sequencer

Parametrised instruction sequencer for the BitBlaster processor family. It owns the timestep state machine, decodes the instruction register, and drives every datapath control signal: register-file addresses and enables, the A/G latches, the ALU opcode, the immediate path and the external-data path. Compared with the fixed 10-bit controller, it adds:
- generic data and register-address widths;
- a Start/Busy/Done handshake;
- a Stall input;
- illegal-instruction detection;
- an IMM output that is never tri-stated.

## Interface
- DATA_W, 10: bus/instruction width; must be ≥ 2+2·REG_AW+4.
- REG_AW, 2: register address width (2^REG_AW registers).
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  begin one instruction; sampled only in IDLE.
- Stall  in  1  freeze state; all enables forced low while high.
- INST  in  DATA_W  instruction register contents, valid from T1 onward.
- IMM  out  DATA_W  zero-extended immediate; 0 unless ImmOE.
- ImmOE  out  1  immediate drives bus.
- Rin  out  REG_AW  register-file write address.
- Rout  out  REG_AW  register-file read address.
- ENW  out  1  register file drives bus.
- ENR  out  1  register file loads from bus.
- Ain  out  1  A latch loads.
- Gin  out  1  G latch loads.
- Gout  out  1  G drives bus.
- ALUcont  out  4  ALU operation; 0 when unused.
- Ext  out  1  external data drives bus.
- IRin  out  1  instruction register loads.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse on an instruction's last cycle.
- Err  out  1  one-cycle pulse on an illegal instruction.
- Tstep  out  2  current timestep for display (0 in IDLE).

## Operation

Instruction fields:
- class = INST[W-1:W-2];
- Rx = INST[W-3:W-2-REG_AW];
- Ry = the next REG_AW bits;
- op = INST[3:0];
- imm = INST[W-3-REG_AW:0], zero-extended to DATA_W.

States: IDLE, T0, T1, T2, T3.
- IDLE: all outputs low/zero. Start → T0.
- T0 (fetch): Ext=1, IRin=1 → T1.
- T1, depending on the instruction:
  - ld (class 00, op 0000): Ext=1, Rin=Rx, ENR=1, Done → IDLE.
  - cp (class 00, op 0001): Rout=Ry, ENW=1, Rin=Rx, ENR=1, Done → IDLE.
  - Illegal (class 01, or class 00 with op ≥ 1100): no enables asserted; Err=1, Done=1 → IDLE.
  - All other instructions: Rout=Rx, ENW=1, Ain=1 → T2.
- T2, depending on class:
  - Class 00: Rout=Ry, ENW=1, ALUcont=op, Gin=1.
  - Class 10: ImmOE=1, IMM=imm, ALUcont=0010, Gin=1.
  - Class 11: the same with ALUcont=0011.
  - All classes → T3.
- T3: Gout=1, Rin=Rx, ENR=1, Done → IDLE.

At most one bus driver (ENW, Gout, Ext, ImmOE) is high in any cycle.

## Timing
- Outputs are a combinational decode of the registered state, INST and Stall. The state register alone is sequential.
- Reset: state=IDLE, so every output is 0, including Busy, Done and Err.
- Latency from the Start cycle (Start accepted in IDLE at edge 0):
  - ld, cp, illegal: Done asserted in T1, the 3rd cycle after Start.
  - ALU and immediate instructions: Done asserted in T3, the 5th cycle.
  - Back-to-back Start sampled in the cycle after Done begins the next fetch with no gap beyond IDLE.
- Start while Busy is ignored; it is not queued.
- Stall is high-priority over advance:
  - state holds;
  - all enables, Done and Err are 0;
  - IMM=0, ALUcont=0;
  - Busy stays high; Tstep shows the held step.
- Stall in IDLE blocks Start.
- Reset mid-instruction: IDLE on the next edge. No partial write occurs after that edge.
- Reset and Start together: Reset wins.

## Structure
- Package ctrl_pkg holds:
  - state enum (IDLE, T0–T3);
  - class constants CLS_ALU=00, CLS_ADDI=10, CLS_SUBI=11;
  - opcode constants LOAD…ASR (0000–1011), ALU_ADD=0010, ALU_SUB=0011.
- Sub-module ctrl_decode (combinational) extracts class, Rx, Ry, op and imm, and flags is_ld, is_cp and illegal, parametrised by DATA_W/REG_AW.
- ctrl_sequencer holds the state register and the output decode.

## Test plan
- Reset held 3 cycles with Start=1 → state IDLE; every output 0; Busy=0.
- INST=00_10_01_0001 (cp R2,R1), Start pulse → T1 has Rout=01, Rin=10, ENW=ENR=1, Done=1; Busy drops the next cycle; 3 cycles total.
- INST=00_01_11_0010 (add) → T1 Rout=01, Ain=1; T2 Rout=11, ALUcont=0010, Gin=1; T3 Gout=1, Rin=01, ENR=1, Done=1.
- INST=11_00_101101 (subi) → T2 ImmOE=1, IMM=0000101101, ALUcont=0011, ENW=0; IMM=0 in all other cycles.
- INST=01_xx_xxxx_xx and INST=00_00_00_1110 → T1 Err=1, Done=1, no enables asserted; Start during T0 of the next instruction is ignored.
- Stall raised 2 cycles in T2 of an add → enables 0, Tstep=2 held; resumes with Gin in T2, Done 2 cycles late. Reset asserted in T2 → IDLE, no ENR pulse. Rerun with DATA_W=16, REG_AW=3.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the BitBlaster instruction sequencer.
package ctrl_pkg;

  // Timestep states; IDLE sits between instructions.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T0   = 3'd1,
    ST_T1   = 3'd2,
    ST_T2   = 3'd3,
    ST_T3   = 3'd4
  } state_t;

  // Instruction classes (INST top two bits).
  localparam logic [1:0] CLS_ALU  = 2'b00;
  localparam logic [1:0] CLS_ILL  = 2'b01;
  localparam logic [1:0] CLS_ADDI = 2'b10;
  localparam logic [1:0] CLS_SUBI = 2'b11;

  // Class-00 opcodes; everything from OP_ILL_MIN upward is undefined.
  localparam logic [3:0] OP_LOAD    = 4'b0000;
  localparam logic [3:0] OP_COPY    = 4'b0001;
  localparam logic [3:0] OP_ADD     = 4'b0010;
  localparam logic [3:0] OP_SUB     = 4'b0011;
  localparam logic [3:0] OP_AND     = 4'b0100;
  localparam logic [3:0] OP_OR      = 4'b0101;
  localparam logic [3:0] OP_XOR     = 4'b0110;
  localparam logic [3:0] OP_NOT     = 4'b0111;
  localparam logic [3:0] OP_SHL     = 4'b1000;
  localparam logic [3:0] OP_SHR     = 4'b1001;
  localparam logic [3:0] OP_ROR     = 4'b1010;
  localparam logic [3:0] OP_ASR     = 4'b1011;
  localparam logic [3:0] OP_ILL_MIN = 4'b1100;

  // ALU codes used by the immediate instructions.
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;

  // Display timestep for a state; IDLE and T0 both show 0.
  function automatic logic [1:0] tstep_of(state_t s);
    case (s)
      ST_T1:   return 2'd1;
      ST_T2:   return 2'd2;
      ST_T3:   return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Control/handshake bundle between the sequencer and its datapath/host.
//
// Handshake: the host raises Start while Busy is low; the sequencer accepts
// it on that edge (unless Stall or Reset is high) and holds Busy high until
// the instruction completes. Done pulses for exactly one cycle on the last
// cycle of the instruction (Err alongside it for an illegal instruction).
// Start seen while Busy is high is dropped, never queued. INST must stay
// stable from T1 until Done.
interface ctrl_sequencer_if #(
  parameter int DATA_W = 10,
  parameter int REG_AW = 2
);
  import ctrl_pkg::*;

  logic              Start;
  logic              Stall;
  logic [DATA_W-1:0] INST;
  logic [DATA_W-1:0] IMM;
  logic              ImmOE;
  logic [REG_AW-1:0] Rin;
  logic [REG_AW-1:0] Rout;
  logic              ENW;
  logic              ENR;
  logic              Ain;
  logic              Gin;
  logic              Gout;
  logic [3:0]        ALUcont;
  logic              Ext;
  logic              IRin;
  logic              Busy;
  logic              Done;
  logic              Err;
  logic [1:0]        Tstep;
  state_t            state_dbg;

  modport master (
    input  Start, Stall, INST,
    output IMM, ImmOE, Rin, Rout, ENW, ENR, Ain, Gin, Gout, ALUcont,
           Ext, IRin, Busy, Done, Err, Tstep, state_dbg
  );

  modport slave (
    output Start, Stall, INST,
    input  IMM, ImmOE, Rin, Rout, ENW, ENR, Ain, Gin, Gout, ALUcont,
           Ext, IRin, Busy, Done, Err, Tstep, state_dbg
  );

endinterface

// File: rtl/ctrl_decode.sv
// Field extraction and classification of the instruction register.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int REG_AW = 2
) (
  input  logic [DATA_W-1:0] inst,
  output logic [1:0]        cls,
  output logic [REG_AW-1:0] rx,
  output logic [REG_AW-1:0] ry,
  output logic [3:0]        op,
  output logic [DATA_W-1:0] imm,
  output logic              is_ld,
  output logic              is_cp,
  output logic              illegal
);

  // The immediate overlaps Ry and op; only the class and Rx bits are excluded.
  assign cls = inst[DATA_W-1 -: 2];
  assign rx  = inst[DATA_W-3 -: REG_AW];
  assign ry  = inst[DATA_W-3-REG_AW -: REG_AW];
  assign op  = inst[3:0];
  assign imm = {{(2+REG_AW){1'b0}}, inst[DATA_W-3-REG_AW:0]};

  assign is_ld   = (cls == CLS_ALU) && (op == OP_LOAD);
  assign is_cp   = (cls == CLS_ALU) && (op == OP_COPY);
  assign illegal = (cls == CLS_ILL) || ((cls == CLS_ALU) && (op >= OP_ILL_MIN));

endmodule

// File: rtl/ctrl_sequencer.sv
// Timestep state machine and datapath control decode for BitBlaster.
// Only the state is registered; every control output is decoded from the
// current state, INST and Stall so the datapath sees it in the same cycle.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int REG_AW = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  ctrl_sequencer_if.master bus
);

  state_t            state;
  logic [1:0]        cls;
  logic [REG_AW-1:0] rx;
  logic [REG_AW-1:0] ry;
  logic [3:0]        op;
  logic [DATA_W-1:0] imm;
  logic              is_ld;
  logic              is_cp;
  logic              illegal;

  logic [DATA_W-1:0] imm_o;
  logic              imm_oe;
  logic [REG_AW-1:0] rin;
  logic [REG_AW-1:0] rout;
  logic              enw;
  logic              enr;
  logic              ain;
  logic              gin;
  logic              gout;
  logic [3:0]        alu;
  logic              ext;
  logic              irin;
  logic              done;
  logic              err;

  ctrl_decode #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_decode (
    .inst    (bus.INST),
    .cls     (cls),
    .rx      (rx),
    .ry      (ry),
    .op      (op),
    .imm     (imm),
    .is_ld   (is_ld),
    .is_cp   (is_cp),
    .illegal (illegal)
  );

  // State register: reset to IDLE, hold under Stall, otherwise advance.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= ST_IDLE;
    end else if (!bus.Stall) begin
      case (state)
        ST_IDLE: if (bus.Start) state <= ST_T0;
        ST_T0:   state <= ST_T1;
        ST_T1:   state <= (is_ld || is_cp || illegal) ? ST_IDLE : ST_T2;
        ST_T2:   state <= ST_T3;
        ST_T3:   state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Control decode; Stall masks every enable, address and code to zero.
  always_comb begin
    imm_o  = '0;
    imm_oe = 1'b0;
    rin    = '0;
    rout   = '0;
    enw    = 1'b0;
    enr    = 1'b0;
    ain    = 1'b0;
    gin    = 1'b0;
    gout   = 1'b0;
    alu    = 4'd0;
    ext    = 1'b0;
    irin   = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    if (!bus.Stall) begin
      case (state)
        ST_T0: begin
          ext  = 1'b1;
          irin = 1'b1;
        end
        ST_T1: begin
          if (illegal) begin
            err  = 1'b1;
            done = 1'b1;
          end else if (is_ld) begin
            ext  = 1'b1;
            rin  = rx;
            enr  = 1'b1;
            done = 1'b1;
          end else if (is_cp) begin
            rout = ry;
            enw  = 1'b1;
            rin  = rx;
            enr  = 1'b1;
            done = 1'b1;
          end else begin
            rout = rx;
            enw  = 1'b1;
            ain  = 1'b1;
          end
        end
        ST_T2: begin
          gin = 1'b1;
          if (cls == CLS_ALU) begin
            rout = ry;
            enw  = 1'b1;
            alu  = op;
          end else begin
            imm_oe = 1'b1;
            imm_o  = imm;
            alu    = (cls == CLS_SUBI) ? ALU_SUB : ALU_ADD;
          end
        end
        ST_T3: begin
          gout = 1'b1;
          rin  = rx;
          enr  = 1'b1;
          done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.IMM       = imm_o;
  assign bus.ImmOE     = imm_oe;
  assign bus.Rin       = rin;
  assign bus.Rout      = rout;
  assign bus.ENW       = enw;
  assign bus.ENR       = enr;
  assign bus.Ain       = ain;
  assign bus.Gin       = gin;
  assign bus.Gout      = gout;
  assign bus.ALUcont   = alu;
  assign bus.Ext       = ext;
  assign bus.IRin      = irin;
  assign bus.Done      = done;
  assign bus.Err       = err;
  assign bus.Busy      = (state != ST_IDLE);
  assign bus.Tstep     = tstep_of(state);
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: directed scenarios on a 10/2 build
// plus randomized traffic on both a 10/2 and a 16/3 build.
module tb_ctrl_sequencer;
  import ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ctrl_sequencer_if #(.DATA_W(10), .REG_AW(2)) ifa ();
  ctrl_sequencer_if #(.DATA_W(16), .REG_AW(3)) ifb ();

  ctrl_sequencer #(.DATA_W(10), .REG_AW(2)) dut_a (.Clock(clk), .Reset(rst), .bus(ifa.master));
  ctrl_sequencer #(.DATA_W(16), .REG_AW(3)) dut_b (.Clock(clk), .Reset(rst), .bus(ifb.master));

  int errors = 0;
  int checks = 0;

  // Reference model: current timestep per build (-1 = idle) and the instruction.
  int          step_a = -1;
  int          step_b = -1;
  logic [31:0] inst_a = '0;
  logic [31:0] inst_b = '0;

  // ---------------- reference model ----------------
  function automatic int unsigned fld(logic [31:0] v, int lo, int n);
    return (v >> lo) & ((32'd1 << n) - 32'd1);
  endfunction

  function automatic bit is_short(logic [31:0] inst, int w);
    int unsigned cls, op;
    cls = fld(inst, w - 2, 2);
    op  = fld(inst, 0, 4);
    return (cls == 1) || (cls == 0 && (op <= 1 || op >= 12));
  endfunction

  function automatic int next_step(int s, logic [31:0] inst, int w, bit r, bit start, bit stall);
    if (r) return -1;
    if (stall) return s;
    case (s)
      -1:      return start ? 0 : -1;
      0:       return 1;
      1:       return is_short(inst, w) ? -1 : 2;
      2:       return 3;
      default: return -1;
    endcase
  endfunction

  // Expected outputs packed as {pad, imm32, immoe, rin4, rout4, enw, enr, ain,
  // gin, gout, alu4, ext, irin, busy, done, err, tstep2}.
  function automatic logic [63:0] exp_vec(logic [31:0] inst, int w, int ra, int step, bit stall);
    logic [31:0] imm;
    logic [3:0]  rin, rout, alu;
    logic        immoe, enw, enr, ain, gin, gout, ext, irin, busy, done, err;
    logic [1:0]  ts;
    int unsigned cls, rx, ry, op;
    imm = '0; rin = '0; rout = '0; alu = '0; ts = '0;
    immoe = 0; enw = 0; enr = 0; ain = 0; gin = 0; gout = 0;
    ext = 0; irin = 0; busy = 0; done = 0; err = 0;
    cls = fld(inst, w - 2, 2);
    rx  = fld(inst, w - 2 - ra, ra);
    ry  = fld(inst, w - 2 - 2 * ra, ra);
    op  = fld(inst, 0, 4);
    if (step >= 0) begin
      busy = 1;
      ts   = 2'(step);
    end
    if (step >= 0 && !stall) begin
      case (step)
        0: begin ext = 1; irin = 1; end
        1: begin
          if (cls == 1 || (cls == 0 && op >= 12)) begin
            err = 1; done = 1;
          end else if (cls == 0 && op == 0) begin
            ext = 1; rin = 4'(rx); enr = 1; done = 1;
          end else if (cls == 0 && op == 1) begin
            rout = 4'(ry); enw = 1; rin = 4'(rx); enr = 1; done = 1;
          end else begin
            rout = 4'(rx); enw = 1; ain = 1;
          end
        end
        2: begin
          gin = 1;
          if (cls == 0) begin
            rout = 4'(ry); enw = 1; alu = 4'(op);
          end else begin
            immoe = 1; imm = fld(inst, 0, w - 2 - ra); alu = (cls == 3) ? 4'd3 : 4'd2;
          end
        end
        default: begin gout = 1; rin = 4'(rx); enr = 1; done = 1; end
      endcase
    end
    return {7'd0, imm, immoe, rin, rout, enw, enr, ain, gin, gout, alu, ext, irin, busy, done, err, ts};
  endfunction

  function automatic logic [63:0] obs_a();
    return {7'd0, 32'(ifa.IMM), ifa.ImmOE, 4'(ifa.Rin), 4'(ifa.Rout), ifa.ENW, ifa.ENR, ifa.Ain,
            ifa.Gin, ifa.Gout, ifa.ALUcont, ifa.Ext, ifa.IRin, ifa.Busy, ifa.Done, ifa.Err, ifa.Tstep};
  endfunction

  function automatic logic [63:0] obs_b();
    return {7'd0, 32'(ifb.IMM), ifb.ImmOE, 4'(ifb.Rin), 4'(ifb.Rout), ifb.ENW, ifb.ENR, ifb.Ain,
            ifb.Gin, ifb.Gout, ifb.ALUcont, ifb.Ext, ifb.IRin, ifb.Busy, ifb.Done, ifb.Err, ifb.Tstep};
  endfunction

  // ---------------- driver tasks ----------------
  // Advance one clock; the model consumes the inputs present at the edge.
  task automatic tick();
    @(posedge clk);
    step_a = next_step(step_a, inst_a, 10, rst, ifa.Start, ifa.Stall);
    step_b = next_step(step_b, inst_b, 16, rst, ifb.Start, ifb.Stall);
    @(negedge clk);
  endtask

  task automatic set_in(bit start, bit stall, bit r);
    ifa.Start = start;
    ifa.Stall = stall;
    rst       = r;
    #1;
  endtask

  task automatic load_a(logic [9:0] inst);
    inst_a   = 32'(inst);
    ifa.INST = inst;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      set_in(1, 0, 1);
      tick();
      checks++;
      if (obs_a() !== 64'd0 || ifa.state_dbg !== ST_IDLE) begin
        errors++;
        $display("FAIL reset c%0d got=%h state=%0d req=0 IDLE", c, obs_a(), ifa.state_dbg);
      end
    end
    set_in(0, 0, 0);
  endtask

  task automatic test_cp();
    int busy_n = 0;
    int done_at = -1;
    load_a(10'b00_10_01_0001);
    for (int c = 0; c < 5; c++) begin
      set_in(c == 0, 0, 0);
      checks++;
      if (obs_a() !== exp_vec(inst_a, 10, 2, step_a, 0)) begin
        errors++;
        $display("FAIL cp c%0d got=%h req=%h", c, obs_a(), exp_vec(inst_a, 10, 2, step_a, 0));
      end
      if (c == 2) begin
        checks++;
        if ({ifa.Rout, ifa.Rin, ifa.ENW, ifa.ENR, ifa.Done} !== 7'b01_10_111) begin
          errors++;
          $display("FAIL cp_t1 got=%b req=0110111", {ifa.Rout, ifa.Rin, ifa.ENW, ifa.ENR, ifa.Done});
        end
      end
      if (ifa.Busy === 1'b1) busy_n++;
      if (ifa.Done === 1'b1 && done_at < 0) done_at = c;
      tick();
    end
    checks++;
    if (done_at != 2 || busy_n != 2) begin
      errors++;
      $display("FAIL cp_latency got done_at=%0d busy=%0d req 2 2", done_at, busy_n);
    end
  endtask

  task automatic test_add();
    int done_at = -1;
    load_a(10'b00_01_11_0010);
    for (int c = 0; c < 7; c++) begin
      set_in(c == 0, 0, 0);
      checks++;
      if (obs_a() !== exp_vec(inst_a, 10, 2, step_a, 0)) begin
        errors++;
        $display("FAIL add c%0d got=%h req=%h", c, obs_a(), exp_vec(inst_a, 10, 2, step_a, 0));
      end
      if (c == 3) begin
        checks++;
        if ({ifa.Rout, ifa.ALUcont, ifa.Gin, ifa.ENW} !== 8'b11_0010_11) begin
          errors++;
          $display("FAIL add_t2 got=%b req=11001011", {ifa.Rout, ifa.ALUcont, ifa.Gin, ifa.ENW});
        end
      end
      if (ifa.Done === 1'b1 && done_at < 0) done_at = c;
      tick();
    end
    checks++;
    if (done_at != 4) begin
      errors++;
      $display("FAIL add_latency got=%0d req=4", done_at);
    end
  endtask

  task automatic test_subi();
    load_a(10'b11_00_101101);
    for (int c = 0; c < 7; c++) begin
      set_in(c == 0, 0, 0);
      checks++;
      if (obs_a() !== exp_vec(inst_a, 10, 2, step_a, 0)) begin
        errors++;
        $display("FAIL subi c%0d got=%h req=%h", c, obs_a(), exp_vec(inst_a, 10, 2, step_a, 0));
      end
      checks++;
      if (c == 3) begin
        if ({ifa.IMM, ifa.ImmOE, ifa.ALUcont, ifa.ENW} !== 16'b0000101101_1_0011_0) begin
          errors++;
          $display("FAIL subi_t2 got=%b req=0000101101100110", {ifa.IMM, ifa.ImmOE, ifa.ALUcont, ifa.ENW});
        end
      end else if (ifa.IMM !== 10'd0) begin
        errors++;
        $display("FAIL subi_imm_idle c%0d got=%h req=0", c, ifa.IMM);
      end
      tick();
    end
  endtask

  task automatic test_illegal();
    logic [9:0] insts [2];
    insts[0] = {2'b01, 8'($urandom_range(0, 255))};
    insts[1] = 10'b00_00_00_1110;
    for (int k = 0; k < 2; k++) begin
      int done_n = 0;
      int err_n = 0;
      load_a(insts[k]);
      for (int c = 0; c < 5; c++) begin
        set_in(c <= 1, 0, 0);
        checks++;
        if (obs_a() !== exp_vec(inst_a, 10, 2, step_a, 0)) begin
          errors++;
          $display("FAIL illegal%0d c%0d got=%h req=%h", k, c, obs_a(), exp_vec(inst_a, 10, 2, step_a, 0));
        end
        if (c == 2) begin
          checks++;
          if ({ifa.ENW, ifa.ENR, ifa.Ain, ifa.Gin, ifa.Gout, ifa.Ext, ifa.IRin, ifa.ImmOE, ifa.Err, ifa.Done} !== 10'b0000000011) begin
            errors++;
            $display("FAIL illegal%0d_t1 got=%b req=0000000011", k,
                     {ifa.ENW, ifa.ENR, ifa.Ain, ifa.Gin, ifa.Gout, ifa.Ext, ifa.IRin, ifa.ImmOE, ifa.Err, ifa.Done});
          end
        end
        if (ifa.Done === 1'b1) done_n++;
        if (ifa.Err === 1'b1) err_n++;
        tick();
      end
      checks++;
      if (done_n != 1 || err_n != 1) begin
        errors++;
        $display("FAIL illegal%0d_pulses got done=%0d err=%0d req 1 1", k, done_n, err_n);
      end
    end
  endtask

  task automatic test_stall();
    int done_at = -1;
    load_a(10'b00_01_11_0010);
    for (int c = 0; c < 9; c++) begin
      set_in(c == 0, (c == 3 || c == 4), 0);
      checks++;
      if (obs_a() !== exp_vec(inst_a, 10, 2, step_a, ifa.Stall)) begin
        errors++;
        $display("FAIL stall c%0d got=%h req=%h", c, obs_a(), exp_vec(inst_a, 10, 2, step_a, ifa.Stall));
      end
      if (c == 4) begin
        checks++;
        if ({ifa.Tstep, ifa.Busy, ifa.ENW, ifa.Gin, ifa.ALUcont} !== 9'b10_1_0_0_0000) begin
          errors++;
          $display("FAIL stall_hold got=%b req=101000000", {ifa.Tstep, ifa.Busy, ifa.ENW, ifa.Gin, ifa.ALUcont});
        end
      end
      if (c == 5) begin
        checks++;
        if (ifa.Gin !== 1'b1) begin
          errors++;
          $display("FAIL stall_resume got=%b req=1", ifa.Gin);
        end
      end
      if (ifa.Done === 1'b1 && done_at < 0) done_at = c;
      tick();
    end
    checks++;
    if (done_at != 6) begin
      errors++;
      $display("FAIL stall_latency got=%0d req=6", done_at);
    end
    // Stall in IDLE must block Start.
    for (int c = 0; c < 2; c++) begin
      set_in(1, 1, 0);
      tick();
    end
    set_in(0, 0, 0);
    checks++;
    if (ifa.Busy !== 1'b0 || step_a != -1) begin
      errors++;
      $display("FAIL stall_idle got busy=%b req=0", ifa.Busy);
    end
  endtask

  task automatic test_reset_mid();
    int enr_n = 0;
    load_a(10'b00_10_01_0110);
    for (int c = 0; c < 7; c++) begin
      set_in(c == 0, 0, c == 3);
      checks++;
      if (obs_a() !== exp_vec(inst_a, 10, 2, step_a, 0)) begin
        errors++;
        $display("FAIL reset_mid c%0d got=%h req=%h", c, obs_a(), exp_vec(inst_a, 10, 2, step_a, 0));
      end
      if (c >= 3 && ifa.ENR === 1'b1) enr_n++;
      tick();
    end
    checks++;
    if (enr_n != 0 || ifa.Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_write got enr=%0d busy=%b req 0 0", enr_n, ifa.Busy);
    end
  endtask

  task automatic test_back_to_back();
    int done_n = 0;
    int last_done = -1;
    load_a(10'b00_11_00_0001);
    for (int c = 0; c < 7; c++) begin
      set_in(1, 0, 0);
      checks++;
      if (obs_a() !== exp_vec(inst_a, 10, 2, step_a, 0)) begin
        errors++;
        $display("FAIL b2b c%0d got=%h req=%h", c, obs_a(), exp_vec(inst_a, 10, 2, step_a, 0));
      end
      if (ifa.Done === 1'b1) begin
        done_n++;
        last_done = c;
      end
      tick();
    end
    set_in(0, 0, 0);
    tick();
    checks++;
    if (done_n != 2 || last_done != 5) begin
      errors++;
      $display("FAIL b2b_count got done=%0d last=%0d req 2 5", done_n, last_done);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if (step_a == -1 && $urandom_range(0, 1) == 1) begin
        inst_a   = 32'($urandom_range(0, 1023));
        ifa.INST = inst_a[9:0];
      end
      if (step_b == -1 && $urandom_range(0, 1) == 1) begin
        inst_b   = 32'($urandom_range(0, 65535));
        ifb.INST = inst_b[15:0];
      end
      ifa.Start = ($urandom_range(0, 2) != 0);
      ifa.Stall = ($urandom_range(0, 5) == 0);
      ifb.Start = ($urandom_range(0, 2) != 0);
      ifb.Stall = ($urandom_range(0, 5) == 0);
      rst       = ($urandom_range(0, 60) == 0);
      #1;
      checks++;
      if (obs_a() !== exp_vec(inst_a, 10, 2, step_a, ifa.Stall)) begin
        errors++;
        $display("FAIL rand_a c%0d got=%h req=%h", c, obs_a(), exp_vec(inst_a, 10, 2, step_a, ifa.Stall));
      end
      checks++;
      if (obs_b() !== exp_vec(inst_b, 16, 3, step_b, ifb.Stall)) begin
        errors++;
        $display("FAIL rand_b c%0d got=%h req=%h", c, obs_b(), exp_vec(inst_b, 16, 3, step_b, ifb.Stall));
      end
      tick();
    end
    rst = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    ifa.Start = 0; ifa.Stall = 0; ifa.INST = '0;
    ifb.Start = 0; ifb.Stall = 0; ifb.INST = '0;
    test_reset();
    test_cp();
    test_add();
    test_subi();
    test_illegal();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
